// File: rtl/countdown_driver_pkg.sv
// countdown_driver_pkg: shared types and constants for the countdown driver.
//   state_t        : driver FSM state, 2-bit encoding
//   DEFAULT_*      : default counter and prescaler widths
//   done_latency() : cycles from command handshake to the done pulse
package countdown_driver_pkg;

  localparam int DEFAULT_WIDTH      = 4;
  localparam int DEFAULT_PRESCALE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Handshake at cycle 0, one LOAD cycle, count*(period+1) RUN cycles issuing
  // dec, one RUN cycle observing zero, then the DONE cycle.
  function automatic int unsigned done_latency(input int unsigned count,
                                               input int unsigned period);
    return count * (period + 1) + 3;
  endfunction

endpackage

// File: rtl/countdown_driver_dec_prescaler.sv
// dec_prescaler: strobe-rate generator. Counts enabled cycles and raises hit
// when the count equals period; the count restarts from 0 after a hit.
//   clock, reset_n : clock, async active-low reset
//   clear          : synchronous restart of the count (wins over enable)
//   enable         : advance the count this cycle
//   period         : idle cycles between hits (0 = hit every enabled cycle)
//   hit            : combinational, count == period
module dec_prescaler
  import countdown_driver_pkg::*;
#(
  parameter int PRESCALE_W = DEFAULT_PRESCALE_W
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  clear,
  input  logic                  enable,
  input  logic [PRESCALE_W-1:0] period,
  output logic                  hit
);

  logic [PRESCALE_W-1:0] cnt_q;

  assign hit = (cnt_q == period);

  // The count never exceeds period, so it cannot wrap.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable) begin
      if (hit) cnt_q <= '0;
      else     cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/countdown_driver.sv
// countdown_driver: initiator for a latch/dec/zero countdown counter.
// Accepts a timed-wait command (count, period) on a valid/ready handshake,
// loads the counter, issues dec at the prescaled rate until zero, then pulses
// done for one cycle. cmd_abort in LOAD/RUN returns to IDLE silently.
//   clock, reset_n          : clock, async active-low reset
//   cmd_valid/cmd_ready     : command handshake (ready only in IDLE)
//   cmd_count, cmd_period   : count to load, idle cycles between decs
//   cmd_abort               : cancel the active command
//   latch, in, dec          : counter load strobe, load value, decrement strobe
//   zero                    : counter == 0
//   busy, done, err         : not idle, completion pulse, sticky check error
// Optional: define COUNTDOWN_DRIVER_CHECK_EN to build a shadow counter that
// flags a disagreement with the counter's zero flag on err. Otherwise err = 0.
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready=1
// LOAD  | one cycle, latch=1 with the captured count
// RUN   | prescaled dec pulses until zero is seen
// DONE  | one-cycle done pulse
module countdown_driver
  import countdown_driver_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int PRESCALE_W = DEFAULT_PRESCALE_W
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [WIDTH-1:0]      cmd_count,
  input  logic [PRESCALE_W-1:0] cmd_period,
  input  logic                  cmd_abort,
  output logic                  latch,
  output logic [WIDTH-1:0]      in,
  output logic                  dec,
  input  logic                  zero,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  state_t                state_q, state_d;
  logic [WIDTH-1:0]      count_q;
  logic [PRESCALE_W-1:0] period_q;
  logic                  accept;
  logic                  ps_clear;
  logic                  ps_en;
  logic                  ps_hit;

  dec_prescaler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_prescaler (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (ps_clear),
    .enable  (ps_en),
    .period  (period_q),
    .hit     (ps_hit)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      period_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        count_q  <= cmd_count;
        period_q <= cmd_period;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    accept    = 1'b0;
    latch     = 1'b0;
    dec       = 1'b0;
    done      = 1'b0;
    ps_clear  = 1'b0;
    ps_en     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        ps_clear  = 1'b1;
        if (cmd_valid) begin
          accept  = 1'b1;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (cmd_abort) begin
          state_d = ST_IDLE;
        end else begin
          latch    = 1'b1;
          ps_clear = 1'b1;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        if (cmd_abort) begin
          state_d = ST_IDLE;
        end else if (zero) begin
          state_d = ST_DONE;
        end else begin
          ps_en = 1'b1;
          dec   = ps_hit;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign in   = count_q;
  assign busy = (state_q != ST_IDLE);

`ifdef COUNTDOWN_DRIVER_CHECK_EN
  logic [WIDTH-1:0] shadow_q;
  logic             err_q;

  // Shadow tracks what the counter should hold; it follows only the strobes
  // actually issued, so an aborted LOAD leaves it untouched.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      shadow_q <= '0;
      err_q    <= 1'b0;
    end else begin
      if (latch)    shadow_q <= count_q;
      else if (dec) shadow_q <= shadow_q - 1'b1;
      if (accept) begin
        err_q <= 1'b0;
      end else if ((state_q == ST_RUN) && ((shadow_q == '0) != zero)) begin
        err_q <= 1'b1;
      end
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_countdown_driver.sv
module tb_countdown_driver;
  import countdown_driver_pkg::*;

`ifdef COUNTDOWN_DRIVER_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic       clock;
  logic       reset_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_count;
  logic [3:0] cmd_period;
  logic       cmd_abort;
  logic       latch;
  logic [3:0] in_bus;
  logic       dec;
  logic       zero;
  logic       busy;
  logic       done;
  logic       err;

  int checks   = 0;
  int failures = 0;

  countdown_driver dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_count  (cmd_count),
    .cmd_period (cmd_period),
    .cmd_abort  (cmd_abort),
    .latch      (latch),
    .in         (in_bus),
    .dec        (dec),
    .zero       (zero),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Counter model: latch dominates dec, dec ignored at zero. fault pins zero low.
  logic [3:0] ctr = 4'd0;
  logic       fault = 1'b0;
  always @(posedge clock) begin
    if (latch)                 ctr <= in_bus;
    else if (dec && ctr != 0)  ctr <= ctr - 4'd1;
  end
  assign zero = fault ? 1'b0 : (ctr == 4'd0);

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Drives one command and checks every cycle against a timeline computed
  // from the count/period rules: latch at cycle 1, dec k at 1+k*(P+1) for
  // k=1..C, done at C*(P+1)+3, nothing from the abort cycle on.
  task automatic run_cmd(input string name, input logic [3:0] c, input logic [3:0] p,
                         input int abort_at, output int done_at, output int ndec);
    int ci, pi, exp_done, last;
    logic aborted, e_latch, e_dec, e_done, e_busy;
    ci = int'(c);
    pi = int'(p);
    exp_done = (abort_at > 0) ? 0 : ci * (pi + 1) + 3;
    last     = (abort_at > 0) ? abort_at + 1 : exp_done + 1;
    done_at = 0;
    ndec    = 0;
    @(posedge clock); #1;
    cmd_valid = 1'b1; cmd_count = c; cmd_period = p; cmd_abort = 1'b0;
    @(negedge clock);
    check({name, "_ready_c0"}, cmd_ready, 1);
    for (int n = 1; n <= last; n++) begin
      @(posedge clock); #1;
      cmd_valid  = 1'b0;
      cmd_count  = 4'($urandom);
      cmd_period = 4'($urandom);
      cmd_abort  = (n == abort_at);
      @(negedge clock);
      aborted = (abort_at > 0) && (n >= abort_at);
      e_latch = (n == 1) && !aborted;
      e_dec   = !aborted && n >= 2 && ((n - 1) % (pi + 1) == 0) && ((n - 1) / (pi + 1) <= ci);
      e_done  = !aborted && (n == exp_done);
      e_busy  = (abort_at > 0) ? (n <= abort_at) : (n <= exp_done);
      check($sformatf("%s_c%0d_rdy_lat_dec_done_busy_err", name, n),
            {cmd_ready, latch, dec, done, busy, err},
            {!e_busy, e_latch, e_dec, e_done, e_busy, 1'b0});
      if (e_latch) check($sformatf("%s_in", name), in_bus, c);
      if (dec)  ndec++;
      if (done) done_at = n;
    end
  endtask

  typedef struct {
    logic [3:0] count;
    logic [3:0] period;
    int         abort_at;
    int         exp_done;
    int         exp_decs;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int done_at, ndec, ab, ci, pi;
    logic [3:0] c, p;

    vecs[0] = '{4'd3,  4'd0, 0, 6,  3};
    vecs[1] = '{4'd0,  4'd5, 0, 3,  0};
    vecs[2] = '{4'd15, 4'd2, 0, 48, 15};
    vecs[3] = '{4'd4,  4'd1, 5, 0,  1};
    vecs[4] = '{4'd1,  4'd0, 0, 4,  1};
    vecs[5] = '{4'd7,  4'd3, 0, 31, 7};
    vecs[6] = '{4'd2,  4'd4, 1, 0,  0};

    reset_n = 1'b0; cmd_valid = 1'b0; cmd_count = 4'd0; cmd_period = 4'd0; cmd_abort = 1'b0;
    #8;
    check("reset_state", {cmd_ready, latch, dec, done, busy, err, in_bus},
          {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0});
    #4 reset_n = 1'b1;

    foreach (vecs[i]) begin
      run_cmd($sformatf("vec%0d", i), vecs[i].count, vecs[i].period, vecs[i].abort_at, done_at, ndec);
      check($sformatf("vec%0d_done_cycle", i), done_at, vecs[i].exp_done);
      check($sformatf("vec%0d_dec_count", i), ndec, vecs[i].exp_decs);
    end

    for (int r = 0; r < 25; r++) begin
      c = 4'($urandom_range(0, 15));
      p = 4'($urandom_range(0, 3));
      ci = int'(c); pi = int'(p);
      ab = 0;
      if ($urandom_range(0, 3) == 0) ab = $urandom_range(1, ci * (pi + 1) + 2);
      run_cmd($sformatf("rnd%0d", r), c, p, ab, done_at, ndec);
      if (ab == 0) begin
        check($sformatf("rnd%0d_done_cycle", r), done_at, done_latency(ci, pi));
        check($sformatf("rnd%0d_dec_count", r), ndec, ci);
      end else begin
        check($sformatf("rnd%0d_abort_no_done", r), done_at, 0);
      end
    end

    // cmd_abort in IDLE is ignored, also when it coincides with the handshake.
    @(posedge clock); #1; cmd_abort = 1'b1;
    @(negedge clock);
    check("idle_abort_ready_busy", {cmd_ready, busy}, 2'b10);
    @(posedge clock); #1; cmd_valid = 1'b1; cmd_count = 4'd0; cmd_period = 4'd0;
    @(posedge clock); #1; cmd_valid = 1'b0; cmd_abort = 1'b0;
    @(negedge clock);
    check("idle_abort_then_latch", {latch, busy}, 2'b11);
    @(posedge clock); @(posedge clock); @(negedge clock);
    check("idle_abort_done_c3", done, 1);

    // Reset asserted mid-RUN takes effect immediately and yields no done.
    @(posedge clock); #1; cmd_valid = 1'b1; cmd_count = 4'd9; cmd_period = 4'd1;
    @(posedge clock); #1; cmd_valid = 1'b0;
    repeat (4) @(posedge clock);
    #3 reset_n = 1'b0;
    #1;
    check("async_reset_outputs", {cmd_ready, latch, dec, done, busy, err, in_bus},
          {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0});
    @(negedge clock); #2 reset_n = 1'b1;
    ndec = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clock);
      if (done || !cmd_ready || busy) ndec++;
    end
    check("post_reset_idle_no_done", ndec, 0);

    // Counter whose zero never rises: err after the last dec, sticky, cleared on accept.
    fault = 1'b1;
    @(posedge clock); #1; cmd_valid = 1'b1; cmd_count = 4'd2; cmd_period = 4'd0;
    @(posedge clock); #1; cmd_valid = 1'b0;                     // cycle 1
    @(posedge clock); @(posedge clock); @(posedge clock);       // cycle 4
    @(negedge clock);
    check("fault_err_c4", err, 0);
    @(posedge clock); @(negedge clock);
    check("fault_err_c5", err, EXP_ERR);
    @(posedge clock); @(negedge clock);
    check("fault_err_done_c6", {err, done}, {EXP_ERR, 1'b0});
    @(posedge clock); #1; cmd_abort = 1'b1;
    @(posedge clock); #1; cmd_abort = 1'b0; fault = 1'b0;
    @(negedge clock);
    check("fault_err_sticky_idle", {err, cmd_ready}, {EXP_ERR, 1'b1});
    @(posedge clock); #1; cmd_valid = 1'b1; cmd_count = 4'd1; cmd_period = 4'd0;
    @(negedge clock);
    check("fault_err_before_accept", err, EXP_ERR);
    @(posedge clock); #1; cmd_valid = 1'b0;
    @(negedge clock);
    check("fault_err_cleared", err, 0);
    @(posedge clock); @(posedge clock); @(posedge clock); @(negedge clock);
    check("recover_done_c4", {done, err}, 2'b10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
